// File: rtl/sc_reg_serial_loader_if.sv
// Bus bundle between a serial bit source and the serial loader.
// Latency: none, this is a pure signal grouping.
// Backpressure: none; the source gates bits with serial_valid, the loader never stalls it.
//
// Signals:
//   start_InLow   source -> loader   active-low transfer request
//   abort_InLow   source -> loader   active-low abort of the transfer in progress
//   serial_in     source -> loader   serial data bit, MSB first
//   serial_valid  source -> loader   serial_in qualifier
//   data_OutBUS   loader -> source   assembled DATAWIDTH-bit word
//   load_OutLow   loader -> source   active-low one-cycle load strobe
//   clear_OutLow  loader -> source   active-low one-cycle clear strobe
//   busy          loader -> source   transfer in SHIFT/LOAD/CLEAR
//   done          loader -> source   one-cycle pulse after a successful load
interface sc_reg_serial_loader_if #(
  parameter int DATAWIDTH = 8
);
  logic                 start_InLow;
  logic                 abort_InLow;
  logic                 serial_in;
  logic                 serial_valid;
  logic [DATAWIDTH-1:0] data_OutBUS;
  logic                 load_OutLow;
  logic                 clear_OutLow;
  logic                 busy;
  logic                 done;

  // Bit source side.
  modport master (
    output start_InLow, abort_InLow, serial_in, serial_valid,
    input  data_OutBUS, load_OutLow, clear_OutLow, busy, done
  );

  // Loader side.
  modport slave (
    input  start_InLow, abort_InLow, serial_in, serial_valid,
    output data_OutBUS, load_OutLow, clear_OutLow, busy, done
  );
endinterface

// File: rtl/sc_reg_serial_loader.sv
// Deserialises a gated MSB-first bit stream into a word and strobes it into the register stage.
// Latency: load strobe DATAWIDTH+1 cycles after start is driven, with back-to-back valid bits.
// Backpressure: none; the source pauses by dropping serial_valid, TIMEOUT idle cycles drop the word.
//
// Ports:
//   SC_RegGENERAL_CLOCK_50      system clock, rising edge
//   SC_RegGENERAL_RESET_InHigh  asynchronous active-high reset
//   bus                         sc_reg_serial_loader_if.slave (controls in, word/strobes/status out)
module sc_reg_serial_loader #(
  parameter int DATAWIDTH = 8,   // >= 2
  parameter int TIMEOUT   = 16   // >= 1
) (
  input logic                   SC_RegGENERAL_CLOCK_50,
  input logic                   SC_RegGENERAL_RESET_InHigh,
  sc_reg_serial_loader_if.slave bus
);

  localparam int BW = $clog2(DATAWIDTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BITCNT_LAST = BW'(DATAWIDTH - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Only the bits received so far are kept; the final bit is taken straight
  // from serial_in, so the shift register needs one bit less than the word.
  logic [DATAWIDTH-2:0] r_shreg;
  logic [BW-1:0]        r_bitcnt;
  logic [TW-1:0]        r_tocnt;

  logic [DATAWIDTH-1:0] r_data;
  logic                 r_load_n;
  logic                 r_clear_n;
  logic                 r_busy;
  logic                 r_done;

  logic [DATAWIDTH-1:0] w_data_nxt;
  logic                 w_load_n_nxt;
  logic                 w_clear_n_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  logic                 w_start;
  logic                 w_abort;
  logic                 w_bit_last;
  logic                 w_to_last;
  logic [DATAWIDTH-1:0] w_word;

  assign w_start    = ~bus.start_InLow;
  assign w_abort    = ~bus.abort_InLow;
  assign w_bit_last = (r_bitcnt == BITCNT_LAST);
  assign w_to_last  = (r_tocnt == TO_LAST);
  assign w_word     = {r_shreg, bus.serial_in};

  // ---------------------------------------------------------------- state register
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // Abort wins over everything, including the final valid bit.
        if (w_abort)                  w_state_nxt = S_CLEAR;
        else if (bus.serial_valid) begin
          if (w_bit_last)             w_state_nxt = S_LOAD;
        end else if (w_to_last)       w_state_nxt = S_CLEAR;
      end
      S_LOAD:  w_state_nxt = S_IDLE;
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs (next values, registered below)
  always_comb begin
    w_load_n_nxt  = (w_state_nxt != S_LOAD);
    w_clear_n_nxt = (w_state_nxt != S_CLEAR);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (r_state == S_LOAD);
    w_data_nxt    = r_data;
    if (w_state_nxt == S_CLEAR) begin
      w_data_nxt = '0;
    end else if (r_state == S_SHIFT && w_state_nxt == S_LOAD) begin
      w_data_nxt = w_word;
    end
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      r_data    <= '0;
      r_load_n  <= 1'b1;
      r_clear_n <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_data    <= w_data_nxt;
      r_load_n  <= w_load_n_nxt;
      r_clear_n <= w_clear_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------- shift register and counters
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_tocnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_tocnt  <= '0;
          end
        end
        S_SHIFT: begin
          if (!w_abort) begin
            if (bus.serial_valid) begin
              r_shreg  <= w_word[DATAWIDTH-2:0];
              r_tocnt  <= '0;
              // Leaving SHIFT on the last bit: park at 0 rather than wrap.
              r_bitcnt <= w_bit_last ? '0 : r_bitcnt + 1'b1;
            end else begin
              r_tocnt  <= w_to_last ? '0 : r_tocnt + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_shreg  <= '0;
          r_bitcnt <= '0;
          r_tocnt  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_OutBUS  = r_data;
  assign bus.load_OutLow  = r_load_n;
  assign bus.clear_OutLow = r_clear_n;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_sc_reg_serial_loader.sv
// Directed bench for sc_reg_serial_loader (DATAWIDTH=8, TIMEOUT=16).
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_sc_reg_serial_loader;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  sc_reg_serial_loader_if #(.DATAWIDTH(8)) bus ();

  sc_reg_serial_loader #(.DATAWIDTH(8), .TIMEOUT(16)) dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .bus                        (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one valid bit and clock it in.
  task automatic send_bit(input logic b);
    bus.serial_valid = 1'b1;
    bus.serial_in    = b;
    tick();
    bus.serial_valid = 1'b0;
    bus.serial_in    = 1'b0;
  endtask

  // One start sample: IDLE -> SHIFT.
  task automatic do_start();
    bus.start_InLow = 1'b0;
    tick();
    bus.start_InLow = 1'b1;
  endtask

  // Send bits [hi:lo] of w, MSB first, checking no strobe appears early.
  task automatic send_range(input logic [7:0] w, input int hi, input int lo, input string tag);
    for (int i = hi; i >= lo; i--) begin
      send_bit(w[i]);
      if (i != 0) chk({tag, "_noload"}, {31'd0, bus.load_OutLow}, 32'd1);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst              = 1'b1;
    bus.start_InLow  = 1'b1;
    bus.abort_InLow  = 1'b1;
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_data",  {24'd0, bus.data_OutBUS}, 32'h00);
    chk("rst_load",  {31'd0, bus.load_OutLow}, 32'd1);
    chk("rst_clear", {31'd0, bus.clear_OutLow}, 32'd1);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_done",  {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    tick();

    // ---- A5, back-to-back bits: strobe on the 9th edge after start is driven.
    do_start();
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    send_range(8'hA5, 7, 1, "t1");
    chk("t1_partial_data", {24'd0, bus.data_OutBUS}, 32'h00);
    send_bit(1'b1);
    chk("t1_load",  {31'd0, bus.load_OutLow}, 32'd0);
    chk("t1_data",  {24'd0, bus.data_OutBUS}, 32'hA5);
    chk("t1_clear", {31'd0, bus.clear_OutLow}, 32'd1);
    chk("t1_busyL", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("t1_load_end", {31'd0, bus.load_OutLow}, 32'd1);
    chk("t1_done",     {31'd0, bus.done}, 32'd1);
    chk("t1_busy_end", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("t1_done_end", {31'd0, bus.done}, 32'd0);
    chk("t1_hold",     {24'd0, bus.data_OutBUS}, 32'hA5);

    // ---- Abort together with the 8th valid bit: final bit discarded, CLEAR.
    do_start();
    send_range(8'hFF, 7, 1, "t4");
    bus.abort_InLow = 1'b0;
    send_bit(1'b1);
    bus.abort_InLow = 1'b1;
    chk("t4_clear", {31'd0, bus.clear_OutLow}, 32'd0);
    chk("t4_load",  {31'd0, bus.load_OutLow}, 32'd1);
    chk("t4_data",  {24'd0, bus.data_OutBUS}, 32'h00);
    tick();
    chk("t4_clear_end", {31'd0, bus.clear_OutLow}, 32'd1);
    chk("t4_nodone",    {31'd0, bus.done}, 32'd0);
    chk("t4_idle",      {31'd0, bus.busy}, 32'd0);
    chk("t4_load_end",  {31'd0, bus.load_OutLow}, 32'd1);

    // ---- 3C with a 3-cycle gap after 4 bits: strobe 3 cycles later.
    do_start();
    send_range(8'h3C, 7, 4, "t2a");
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("t2_gap_busy", {31'd0, bus.busy}, 32'd1);
      chk("t2_gap_load", {31'd0, bus.load_OutLow}, 32'd1);
    end
    send_range(8'h3C, 3, 1, "t2b");
    chk("t2_partial_data", {24'd0, bus.data_OutBUS}, 32'h00);
    send_bit(1'b0);
    chk("t2_load", {31'd0, bus.load_OutLow}, 32'd0);
    chk("t2_data", {24'd0, bus.data_OutBUS}, 32'h3C);

    // ---- Start held low through the done cycle: next transfer (96) follows immediately.
    bus.start_InLow = 1'b0;
    tick();
    chk("t5b_done", {31'd0, bus.done}, 32'd1);
    chk("t5b_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    bus.start_InLow = 1'b1;
    chk("t5b_shift", {31'd0, bus.busy}, 32'd1);
    chk("t5b_done_end", {31'd0, bus.done}, 32'd0);
    send_range(8'h96, 7, 1, "t5b");
    send_bit(1'b0);
    chk("t5b_load", {31'd0, bus.load_OutLow}, 32'd0);
    chk("t5b_data", {24'd0, bus.data_OutBUS}, 32'h96);
    tick();
    tick();

    // ---- Timeout: 3 bits then 16 idle cycles; CLEAR on the 16th.
    do_start();
    send_range(8'hA0, 7, 5, "t3");
    for (int g = 1; g <= 15; g++) begin
      tick();
      chk("t3_wait_clear", {31'd0, bus.clear_OutLow}, 32'd1);
    end
    tick();
    chk("t3_clear", {31'd0, bus.clear_OutLow}, 32'd0);
    chk("t3_data",  {24'd0, bus.data_OutBUS}, 32'h00);
    chk("t3_load",  {31'd0, bus.load_OutLow}, 32'd1);
    tick();
    chk("t3_clear_end", {31'd0, bus.clear_OutLow}, 32'd1);
    chk("t3_nodone",    {31'd0, bus.done}, 32'd0);
    chk("t3_idle",      {31'd0, bus.busy}, 32'd0);

    // ---- Start pulses during SHIFT are ignored.
    do_start();
    send_range(8'h5A, 7, 5, "t6a");
    bus.start_InLow = 1'b0;
    send_bit(1'b1);
    chk("t6_pulse_load", {31'd0, bus.load_OutLow}, 32'd1);
    tick();
    bus.start_InLow = 1'b1;
    send_range(8'h5A, 3, 1, "t6b");
    send_bit(1'b0);
    chk("t6_load", {31'd0, bus.load_OutLow}, 32'd0);
    chk("t6_data", {24'd0, bus.data_OutBUS}, 32'h5A);
    tick();
    chk("t6_done", {31'd0, bus.done}, 32'd1);
    tick();
    chk("t6_single_load", {31'd0, bus.load_OutLow}, 32'd1);
    chk("t6_idle",        {31'd0, bus.busy}, 32'd0);

    // ---- Asynchronous reset mid-transfer, then a clean FF transfer.
    do_start();
    send_range(8'hB0, 7, 3, "t5");
    rst = 1'b1;
    #2;
    chk("t5_async_data",  {24'd0, bus.data_OutBUS}, 32'h00);
    chk("t5_async_busy",  {31'd0, bus.busy}, 32'd0);
    chk("t5_async_load",  {31'd0, bus.load_OutLow}, 32'd1);
    chk("t5_async_clear", {31'd0, bus.clear_OutLow}, 32'd1);
    chk("t5_async_done",  {31'd0, bus.done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_start();
    send_range(8'hFF, 7, 1, "t5ff");
    send_bit(1'b1);
    chk("t5_ff_load", {31'd0, bus.load_OutLow}, 32'd0);
    chk("t5_ff_data", {24'd0, bus.data_OutBUS}, 32'hFF);
    tick();
    chk("t5_ff_done", {31'd0, bus.done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
